// File: rtl/stage_2_id.sv
// LA32R decode stage: latches fetch payload, reads the register file, resolves branches.
// Define ID_FWD_EN to forward EX/MEM results and stall only on load-use hazards.
module stage_2_id #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_1,
    output logic         allow_2,
    input  logic [63:0]  stage_1_to_2,
    output logic         br_taken,
    output logic [31:0]  br_target,
    output logic         valid_2,
    input  logic         allow_3,
    output logic [147:0] stage_2_to_3,
    input  logic [5:0]   es_dest,
    input  logic [5:0]   ms_dest,
    input  logic [5:0]   ws_dest,
    input  logic         es_is_load,
    input  logic [31:0]  es_fwd,
    input  logic [31:0]  ms_fwd,
    input  logic         ws_rf_we,
    input  logic [4:0]   ws_rf_waddr,
    input  logic [31:0]  ws_rf_wdata
);

    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] rf [32];
    logic        readygo_2;
    logic        stall;

    function automatic logic hit(input logic [4:0] a, input logic [5:0] d);
        return (a != 5'd0) && d[5] && (d[4:0] == a);
    endfunction

    // r0 reads as zero; a same-cycle write to the read address passes straight through
    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic [31:0] stored,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && (wa == a)) return wd;
        return stored;
    endfunction

    logic [4:0] rd, rj, rk;
    assign rd = id_inst[4:0];
    assign rj = id_inst[9:5];
    assign rk = id_inst[14:10];

    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    assign op17 = id_inst[31:15];
    assign op10 = id_inst[31:22];
    assign op7  = id_inst[31:25];
    assign op6  = id_inst[31:26];

    logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
    logic i_slli, i_srli, i_srai, i_addi, i_lu12i, i_ld, i_st;
    logic i_jirl, i_b, i_bl, i_beq, i_bne;
    assign i_add   = op17 == 17'h00020;
    assign i_sub   = op17 == 17'h00022;
    assign i_slt   = op17 == 17'h00024;
    assign i_sltu  = op17 == 17'h00025;
    assign i_nor   = op17 == 17'h00028;
    assign i_and   = op17 == 17'h00029;
    assign i_or    = op17 == 17'h0002a;
    assign i_xor   = op17 == 17'h0002b;
    assign i_slli  = op17 == 17'h00081;
    assign i_srli  = op17 == 17'h00089;
    assign i_srai  = op17 == 17'h00091;
    assign i_addi  = op10 == 10'h00a;
    assign i_ld    = op10 == 10'h0a2;
    assign i_st    = op10 == 10'h0a6;
    assign i_lu12i = op7 == 7'h0a;
    assign i_jirl  = op6 == 6'h13;
    assign i_b     = op6 == 6'h14;
    assign i_bl    = op6 == 6'h15;
    assign i_beq   = op6 == 6'h16;
    assign i_bne   = op6 == 6'h17;

    logic is_3r, is_shift, is_si12, is_link, known;
    assign is_3r    = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
    assign is_shift = i_slli | i_srli | i_srai;
    assign is_si12  = i_addi | i_ld | i_st;
    assign is_link  = i_jirl | i_bl;
    assign known    = is_3r | is_shift | is_si12 | i_lu12i | is_link | i_b | i_beq | i_bne;

    logic rj_read, rk_read, rd_read;
    assign rj_read = known & ~(i_b | i_bl | i_lu12i);
    assign rk_read = is_3r;
    assign rd_read = i_st | i_beq | i_bne;

    logic [31:0] rj_rf, rk_rf, rd_rf;
    assign rj_rf = rf_read(rj, rf[rj], ws_rf_we, ws_rf_waddr, ws_rf_wdata);
    assign rk_rf = rf_read(rk, rf[rk], ws_rf_we, ws_rf_waddr, ws_rf_wdata);
    assign rd_rf = rf_read(rd, rf[rd], ws_rf_we, ws_rf_waddr, ws_rf_wdata);

    logic [31:0] rj_val, rk_val, rd_val;
    logic        rj_haz, rk_haz, rd_haz;
`ifdef ID_FWD_EN
    assign rj_val = hit(rj, es_dest) ? es_fwd : hit(rj, ms_dest) ? ms_fwd : rj_rf;
    assign rk_val = hit(rk, es_dest) ? es_fwd : hit(rk, ms_dest) ? ms_fwd : rk_rf;
    assign rd_val = hit(rd, es_dest) ? es_fwd : hit(rd, ms_dest) ? ms_fwd : rd_rf;
    // Only a load in EX has no result yet to forward
    assign rj_haz = es_is_load & hit(rj, es_dest);
    assign rk_haz = es_is_load & hit(rk, es_dest);
    assign rd_haz = es_is_load & hit(rd, es_dest);
    logic unused_ws;
    assign unused_ws = ^ws_dest;
`else
    assign rj_val = rj_rf;
    assign rk_val = rk_rf;
    assign rd_val = rd_rf;
    assign rj_haz = hit(rj, es_dest) | hit(rj, ms_dest) | hit(rj, ws_dest);
    assign rk_haz = hit(rk, es_dest) | hit(rk, ms_dest) | hit(rk, ws_dest);
    assign rd_haz = hit(rd, es_dest) | hit(rd, ms_dest) | hit(rd, ws_dest);
    logic unused_fwd;
    assign unused_fwd = ^{es_fwd, ms_fwd, es_is_load};
`endif

    assign stall     = id_valid & ((rj_read & rj_haz) | (rk_read & rk_haz) | (rd_read & rd_haz));
    assign readygo_2 = ~stall;
    assign allow_2   = ~id_valid | (readygo_2 & allow_3);
    assign valid_2   = id_valid & readygo_2;

    logic [31:0] si12, ui5, si20, offs16, offs26;
    assign si12   = {{20{id_inst[21]}}, id_inst[21:10]};
    assign ui5    = {27'd0, id_inst[14:10]};
    assign si20   = {id_inst[24:5], 12'd0};
    assign offs16 = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};
    assign offs26 = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};

    assign br_taken  = id_valid & readygo_2 &
                       (i_b | i_bl | i_jirl | (i_beq & (rj_val == rd_val)) |
                        (i_bne & (rj_val != rd_val)));
    assign br_target = i_jirl ? rj_val + offs16 : id_pc + ((i_b | i_bl) ? offs26 : offs16);

    logic [11:0] alu_op;
    assign alu_op = {i_lu12i, i_srai, i_srli, i_slli, i_xor, i_or, i_nor, i_and, i_sltu, i_slt,
                     i_sub, i_add | is_si12 | is_link};

    logic [31:0] src1, src2;
    logic [4:0]  dest;
    logic        rf_we;
    always_comb begin
        src1 = 32'd0;
        src2 = 32'd0;
        if (is_link)      src1 = id_pc;
        else if (rj_read) src1 = rj_val;
        if (is_link)       src2 = 32'd4;
        else if (is_3r)    src2 = rk_val;
        else if (is_shift) src2 = ui5;
        else if (is_si12)  src2 = si12;
        else if (i_lu12i)  src2 = si20;
    end

    assign dest  = i_bl ? 5'd1 : rd;
    assign rf_we = known & ~(i_st | i_b | i_beq | i_bne) & (dest != 5'd0);

    assign stage_2_to_3 = {alu_op, src1, src2, rd_val, i_ld, i_st, rf_we, dest, id_pc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_inst  <= 32'd0;
            id_pc    <= RESET_PC;
        end else if (allow_2) begin
            // Wrong-path payload fetched alongside a redirect is dropped here
            id_valid          <= valid_1 & ~br_taken;
            {id_inst, id_pc}  <= stage_1_to_2;
        end
    end

    always_ff @(posedge clk) begin
        if (ws_rf_we && (ws_rf_waddr != 5'd0)) rf[ws_rf_waddr] <= ws_rf_wdata;
    end

endmodule
